frame_aligner: RTL and testbench
================================

# frame_aligner

Word-to-frame aligner between the GTX receive datapath and the frame sync controller, clocked by `rx_clkout`. It takes unaligned 32-bit RX words and extracts 32-bit frames from a two-word history window at a programmable bit offset. It presents the 2-bit frame header to the sync controller and advances the offset by one bit whenever the controller requests a later frame border. A hold-off timer prevents a slip request from being re-evaluated before the effect of the previous slip has reached the controller.

## Interface
- `DW`, 32: RX word width and frame width.
- `HDR_W`, 2: header width, taken from frame MSBs.
- `SLIP_WAIT`, 8: valid words ignored after a slip before `slip_req` is sampled again (1..255).
- `LOCK_FRAMES`, 64: consecutive header-good valid frames required to declare lock (1..65535).
- `clk`  in  1: RX user clock (`rx_clkout`, 320 MHz).
- `rst_n`  in  1: reset. Asynchronous, active-low.
- `rx_data`  in  DW: raw parallel word from the transceiver.
- `rx_valid`  in  1: `rx_data` valid this cycle.
- `slip_req`  in  1: shift border one bit later; driven by the sync controller's `shift_fr_later`.
- `pattern`  out  HDR_W: header of the current output frame, `frame[DW-1 -: HDR_W]`; feeds the controller's `PATTERN`.
- `frame_data`  out  DW-HDR_W: frame payload.
- `frame_valid`  out  1: `pattern`/`frame_data` valid.
- `bit_offset`  out  5: current extraction offset, 0..DW-1.
- `locked`  out  1: aligner in LOCK state.
- `slip_count`  out  16: total slips since reset, saturating at 16'hFFFF.

## Operation
- History: on each `rx_valid`, `prev_word <= rx_data`. Window `win = {prev_word, rx_data}` (64 bits).
- Extraction: `frame = win[2*DW-1-bit_offset -: DW]`. Offset 0 yields `prev_word` unchanged. Offset k takes the low DW-k bits of `prev_word` followed by the top k bits of `rx_data`.
- Output register: on `rx_valid`, `{pattern, frame_data} <= frame` and `frame_valid <= 1`. Otherwise `frame_valid <= 0` and data holds.
- FSM states are HUNT, WAIT, and LOCK. A "good" frame is a valid frame with `slip_req == 0`.
- HUNT:
  - Valid frame with `slip_req` → `bit_offset` increments (31 wraps to 0), `slip_count` increments, `wait_cnt <= SLIP_WAIT`, go to WAIT, `good_cnt <= 0`.
  - Good frame → `good_cnt` increments. When it reaches LOCK_FRAMES → LOCK.
- WAIT:
  - `slip_req` is ignored.
  - `wait_cnt` decrements per `rx_valid`. At 0 → HUNT with `good_cnt = 0`.
- LOCK:
  - `locked = 1`.
  - Valid frame with `slip_req` → leave lock and perform the HUNT slip action in the same cycle (offset+1, go to WAIT).
  - `slip_req` with `frame_valid == 0` is ignored in every state.
- Reset values: `pattern = 0`, `frame_data = 0`, `frame_valid = 0`, `bit_offset = 0`, `locked = 0`, `slip_count = 0`, `prev_word = 0`, state HUNT, `wait_cnt = 0`, `good_cnt = 0`.
- Reset asserted mid-operation returns everything to the reset values immediately. The first output after reset release uses offset 0 and `prev_word = 0`.

## Timing
- Latency: a word accepted at edge N appears in the frame registered at edge N+1 at offset 0, i.e. 1 cycle from `rx_valid` to `frame_valid`. It is fully contained in output only after the next valid word.
- `slip_req` is sampled in the same cycle as `frame_valid`. The controller drives it combinationally from `pattern`.
- Offset update at edge E. The first output frame at the new offset is registered at the next `rx_valid` edge after E.
- The hold-off spans exactly SLIP_WAIT valid words. Gaps in `rx_valid` stretch it; they do not shorten it.
- Slip rate is bounded to one per SLIP_WAIT+1 valid words. A full 32-position sweep takes at most 32·(SLIP_WAIT+1) valid words.
- `locked` rises on the edge where `good_cnt` reaches LOCK_FRAMES and falls on the slip edge.

## Structure
- Shared package `frame_align_pkg` holds:
  - state enum {HUNT, WAIT, LOCK};
  - `FRAME_DW = 32`, `HDR_W = 2`;
  - `HDR_GOOD = 2'b01`, which the sync controller also uses.
- Sub-module `frame_window_mux`: combinational 64→32 extractor indexed by `bit_offset`, kept separate so it can be retimed or pipelined independently.
- Top level holds the history register, output register, FSM, and counters.

## Test plan
- Offset sweep: stream words carrying frames with header 01 misaligned by 13 bits, with `slip_req = (pattern != 01)` → exactly 13 slips, `bit_offset = 13`, `locked` after 64 further good frames, `slip_count = 13`.
- Wrap-around: start misaligned by 31, drive `slip_req` held high for 32 slip opportunities → `bit_offset` goes 31→0, `slip_count = 32`.
- Hold-off: `slip_req` held constantly high with SLIP_WAIT = 8 → slips exactly every 9th valid word. Insert `rx_valid` gaps → slips remain 9 valid words apart.
- Lock loss: in LOCK, single `slip_req` pulse on a valid frame → `locked` falls that edge, offset+1, WAIT entered, relock after 64 good frames.
- `rx_valid` gaps: deassert `rx_valid` for 5 cycles with `slip_req` high → `frame_valid = 0`, no slip, data and offset held.
- Async reset: assert `rst_n = 0` mid-WAIT with offset 20 → all outputs return to reset values without a clock edge. First post-reset frame at offset 0 equals {0 prev, first word}.

Source files
------------

// File: rtl/frame_aligner_pkg.sv
// frame_align_pkg: shared types and constants for the frame aligner and sync controller
package frame_align_pkg;
    localparam int FRAME_DW = 32;
    localparam int HDR_W = 2;
    localparam logic [1:0] HDR_GOOD = 2'b01;
    typedef enum logic [1:0] {HUNT, WAIT, LOCK} state_t;
endpackage

// File: rtl/frame_window_mux.sv
// frame_window_mux: extracts one DW-bit frame from a two-word window at a bit offset
module frame_window_mux #(
    parameter int DW = 32,
    parameter int OW = $clog2(DW)
) (
    input  logic [2*DW-1:0] win,
    input  logic [OW-1:0]   offset,
    output logic [DW-1:0]   frame
);
    logic [2*DW-1:0] shifted;
    assign shifted = win << offset;
    assign frame = shifted[2*DW-1 -: DW];
endmodule

// File: rtl/frame_aligner.sv
// frame_aligner: bit-slipping word-to-frame aligner with hold-off after each slip
module frame_aligner #(
    parameter int DW = frame_align_pkg::FRAME_DW,
    parameter int HDR_W = frame_align_pkg::HDR_W,
    parameter int SLIP_WAIT = 8,
    parameter int LOCK_FRAMES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DW-1:0]     rx_data,
    input  logic              rx_valid,
    input  logic              slip_req,
    output logic [HDR_W-1:0]  pattern,
    output logic [DW-HDR_W-1:0] frame_data,
    output logic              frame_valid,
    output logic [4:0]        bit_offset,
    output logic              locked,
    output logic [15:0]       slip_count
);
    import frame_align_pkg::*;

    state_t state, nstate;
    logic [DW-1:0] prev_word, frame;
    logic [7:0] wait_cnt;
    logic [15:0] good_cnt;
    logic fire, good;

    frame_window_mux #(.DW(DW), .OW(5)) u_mux (
        .win(({prev_word, rx_data})),
        .offset(bit_offset),
        .frame(frame)
    );

    // slip_req only counts when it qualifies a frame the controller has actually seen
    assign fire = frame_valid && slip_req && state != WAIT;
    assign good = frame_valid && !slip_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= HUNT;
        else
            state <= nstate;
    end

    always_comb begin
        nstate = state;
        if (state == WAIT)
            nstate = (rx_valid && wait_cnt == 8'd1) ? HUNT : WAIT;
        else if (fire)
            nstate = WAIT;
        else if (state == HUNT && good && good_cnt == 16'(LOCK_FRAMES - 1))
            nstate = LOCK;
    end

    always_comb locked = (state == LOCK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_word <= '0;
            pattern <= '0;
            frame_data <= '0;
            frame_valid <= 1'b0;
        end else if (rx_valid) begin
            prev_word <= rx_data;
            {pattern, frame_data} <= frame;
            frame_valid <= 1'b1;
        end else begin
            frame_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_offset <= '0;
            slip_count <= '0;
            wait_cnt <= '0;
            good_cnt <= '0;
        end else if (fire) begin
            bit_offset <= bit_offset + 5'd1;
            slip_count <= (slip_count == 16'hFFFF) ? slip_count : slip_count + 16'd1;
            wait_cnt <= 8'(SLIP_WAIT);
            good_cnt <= '0;
        end else if (state == WAIT && rx_valid) begin
            wait_cnt <= wait_cnt - 8'd1;
            good_cnt <= '0;
        end else if (state == HUNT && good) begin
            good_cnt <= good_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_frame_aligner.sv
// tb_frame_aligner: table vectors plus randomized streams checked against a rule-level model
module tb_frame_aligner;
    import frame_align_pkg::*;
    localparam int SW = 8;
    localparam int LF = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx_valid = 1'b0;
    logic [31:0] rx_data = '0;
    logic slip_req;
    logic [1:0] pattern;
    logic [29:0] frame_data;
    logic frame_valid, locked;
    logic [4:0] bit_offset;
    logic [15:0] slip_count;

    always #5 clk = ~clk;

    frame_aligner #(.SLIP_WAIT(SW), .LOCK_FRAMES(LF)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .slip_req(slip_req), .pattern(pattern), .frame_data(frame_data),
        .frame_valid(frame_valid), .bit_offset(bit_offset), .locked(locked),
        .slip_count(slip_count)
    );

    int tests = 0, fails = 0;
    logic [31:0] m_prev, m_frame;
    logic m_fv, m_locked;
    int m_off, m_slips, m_hold, m_good;
    logic auto_mode = 1'b0, tslip = 1'b0;
    bit spacing_on = 0, seen_slip = 0;
    int vsince = 0;

    // the controller model reacts to the header the model expects, not to the DUT
    always_comb slip_req = auto_mode ? (m_frame[31:30] != HDR_GOOD) : tslip;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    task automatic chk_all();
        chk("frame", 64'({pattern, frame_data}), 64'(m_frame));
        chk("frame_valid", 64'(frame_valid), 64'(m_fv));
        chk("bit_offset", 64'(bit_offset), 64'(m_off));
        chk("locked", 64'(locked), 64'(m_locked));
        chk("slip_count", 64'(slip_count), 64'(m_slips));
    endtask

    task automatic m_reset();
        m_prev = '0; m_frame = '0; m_fv = 1'b0; m_locked = 1'b0;
        m_off = 0; m_slips = 0; m_hold = 0; m_good = 0;
    endtask

    task automatic cyc(input logic rv, input logic [31:0] d);
        logic s, fire;
        logic [63:0] w;
        @(negedge clk);
        rx_valid = rv;
        rx_data = d;
        @(posedge clk);
        s = slip_req;
        #1;
        fire = m_fv && s && m_hold == 0;
        w = {m_prev, d} << m_off;
        if (m_hold > 0) begin
            if (rv) begin
                m_hold--;
                if (m_hold == 0) m_good = 0;
            end
        end else if (fire) begin
            m_off = (m_off + 1) % 32;
            if (m_slips < 65535) m_slips++;
            m_hold = SW;
            m_good = 0;
            m_locked = 1'b0;
        end else if (m_fv && !m_locked) begin
            m_good++;
            if (m_good == LF) m_locked = 1'b1;
        end
        if (rv) begin
            m_frame = w[63:32];
            m_prev = d;
            m_fv = 1'b1;
        end else begin
            m_fv = 1'b0;
        end
        if (spacing_on) begin
            if (fire) begin
                if (seen_slip) chk("slip_spacing", 64'(vsince), 64'(SW));
                seen_slip = 1;
                vsince = 0;
            end else if (rv) begin
                vsince++;
            end
        end
        chk_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        rx_valid = 1'b0;
        auto_mode = 1'b0;
        tslip = 1'b0;
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic rv;
        logic [31:0] d;
        logic sl;
        logic [31:0] ef;
        logic efv;
        logic [4:0] eoff;
    } vec_t;

    vec_t tbl[5];
    logic [31:0] fp, fc;
    int n;
    bit got31;

    initial begin
        tbl[0] = '{1'b1, 32'hA5A5_0001, 1'b0, 32'h0000_0000, 1'b1, 5'd0};
        tbl[1] = '{1'b1, 32'h1234_5678, 1'b1, 32'hA5A5_0001, 1'b1, 5'd1};
        tbl[2] = '{1'b0, 32'h0000_0000, 1'b1, 32'hA5A5_0001, 1'b0, 5'd1};
        tbl[3] = '{1'b1, 32'hFFFF_0000, 1'b0, 32'h2468_ACF1, 1'b1, 5'd1};
        tbl[4] = '{1'b1, 32'h0000_0000, 1'b1, 32'hFFFE_0000, 1'b1, 5'd1};
        m_reset();
        #1;
        chk("rst_frame", 64'({pattern, frame_data}), 64'd0);
        chk("rst_fv", 64'(frame_valid), 64'd0);
        chk("rst_offset", 64'(bit_offset), 64'd0);
        chk("rst_locked", 64'(locked), 64'd0);
        chk("rst_slips", 64'(slip_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            tslip = tbl[i].sl;
            cyc(tbl[i].rv, tbl[i].d);
            chk("tbl_frame", 64'({pattern, frame_data}), 64'(tbl[i].ef));
            chk("tbl_fv", 64'(frame_valid), 64'(tbl[i].efv));
            chk("tbl_offset", 64'(bit_offset), 64'(tbl[i].eoff));
        end

        // offset sweep: frames with header 01 sit 13 bits into each word
        do_reset();
        auto_mode = 1'b1;
        fp = {2'b01, 30'($urandom)};
        for (int i = 0; i < 600; i++) begin
            fc = {2'b01, 30'($urandom)};
            cyc(1'b1, 32'({fp, fc} >> 13));
            fp = fc;
        end
        chk("sweep_offset", 64'(bit_offset), 64'd13);
        chk("sweep_slips", 64'(slip_count), 64'd13);
        chk("sweep_locked", 64'(locked), 64'd1);

        // lock loss on a single slip pulse, then relock
        auto_mode = 1'b0;
        tslip = 1'b1;
        fc = {2'b01, 30'($urandom)};
        cyc(1'b1, 32'({fp, fc} >> 13));
        fp = fc;
        tslip = 1'b0;
        chk("loss_locked", 64'(locked), 64'd0);
        chk("loss_offset", 64'(bit_offset), 64'd14);
        for (int i = 0; i < 80; i++) cyc(1'b1, $urandom);
        chk("relock", 64'(locked), 64'd1);

        // rx_valid gaps with slip_req high must not slip
        cyc(1'b0, $urandom);
        tslip = 1'b1;
        for (int i = 0; i < 5; i++) cyc(1'b0, $urandom);
        chk("gap_fv", 64'(frame_valid), 64'd0);
        chk("gap_offset", 64'(bit_offset), 64'd14);
        chk("gap_slips", 64'(slip_count), 64'd14);
        tslip = 1'b0;

        // wrap-around and hold-off spacing, second half with random gaps
        do_reset();
        tslip = 1'b1;
        spacing_on = 1;
        seen_slip = 0;
        got31 = 0;
        n = 0;
        while (m_slips < 32 && n < 2000) begin
            cyc((m_slips < 16) ? 1'b1 : 1'($urandom_range(0, 3) != 0), $urandom);
            n++;
            if (m_slips == 31 && !got31) begin
                got31 = 1;
                chk("wrap_offset31", 64'(bit_offset), 64'd31);
            end
        end
        spacing_on = 0;
        tslip = 1'b0;
        chk("wrap_offset0", 64'(bit_offset), 64'd0);
        chk("wrap_slips", 64'(slip_count), 64'd32);

        // asynchronous reset in the middle of a hold-off at offset 20
        do_reset();
        tslip = 1'b1;
        n = 0;
        while (m_slips < 20 && n < 1000) begin
            cyc(1'b1, $urandom);
            n++;
        end
        tslip = 1'b0;
        for (int i = 0; i < 3; i++) cyc(1'b1, $urandom);
        chk("pre_rst_offset", 64'(bit_offset), 64'd20);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        rx_valid = 1'b0;
        #1;
        chk("arst_frame", 64'({pattern, frame_data}), 64'd0);
        chk("arst_fv", 64'(frame_valid), 64'd0);
        chk("arst_offset", 64'(bit_offset), 64'd0);
        chk("arst_locked", 64'(locked), 64'd0);
        chk("arst_slips", 64'(slip_count), 64'd0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 32'hDEAD_BEEF);
        chk("post_rst_first", 64'({pattern, frame_data}), 64'd0);
        cyc(1'b1, 32'h0BAD_F00D);
        chk("post_rst_second", 64'({pattern, frame_data}), 64'hDEAD_BEEF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
